// File: rtl/gpio_cfg_pkg.sv
// Shared types and helpers for the GPIO configuration serial loader.
// Sequencer state encoding plus a width helper used to size index and counter fields.
package gpio_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        LOAD  = 2'd3
    } state_t;

    // Bits needed to hold 0..value-1, never less than one so single-entry fields stay legal.
    function automatic int cfg_clog2(input int value);
        int width;
        width = 1;
        while ((32'sd1 <<< width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/gpio_cfg_lane.sv
// One serial chain: read-index generation, control-word staging and the chain's data bit.
// All chains are driven in lock-step by the sequencer in gpio_cfg_loader.
module gpio_cfg_lane
    import gpio_cfg_pkg::*;
#(
    parameter int   CHAIN          = 0,
    parameter int   PADS_PER_CHAIN = 19,
    parameter int   CTRL_BITS      = 13,
    parameter int   IDX_W          = 6,
    parameter int   PAD_W          = 5,
    parameter logic ORDER_UP       = 1'b0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 capture,
    input  logic                 shift,
    input  logic                 clear,
    input  logic [PAD_W-1:0]     pad,
    input  logic [CTRL_BITS-1:0] rd_data,
    output logic [IDX_W-1:0]     rd_idx,
    output logic                 data
);

    // Global index of the pad that goes out first on this chain.
    localparam int FIRST_IDX = ORDER_UP ? (CHAIN * PADS_PER_CHAIN)
                                        : (CHAIN * PADS_PER_CHAIN + PADS_PER_CHAIN - 1);

    logic [CTRL_BITS-1:0] stage_r;
    logic [IDX_W-1:0]     idx_s;
    logic [IDX_W-1:0]     idx_r;

    // Map the shared pad sequence number onto this chain's global pad index.
    always_comb begin
        if (ORDER_UP) begin
            idx_s = IDX_W'(FIRST_IDX) + IDX_W'(pad);
        end else begin
            idx_s = IDX_W'(FIRST_IDX) - IDX_W'(pad);
        end
    end

    // Index register; fed from the sequencer's next pad count so it is valid throughout FETCH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_r <= IDX_W'(FIRST_IDX);
        end else begin
            idx_r <= idx_s;
        end
    end

    // Staging register: load on FETCH, shift out MSB first with zero fill, wipe on abort.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stage_r <= {CTRL_BITS{1'b0}};
        end else if (clear) begin
            stage_r <= {CTRL_BITS{1'b0}};
        end else if (capture) begin
            stage_r <= rd_data;
        end else if (shift) begin
            stage_r <= stage_r << 1'b1;
        end else begin
            stage_r <= stage_r;
        end
    end

    // Zero fill leaves the register empty between pads and during LOAD, so data idles low.
    assign rd_idx = idx_r;
    assign data   = stage_r[CTRL_BITS-1];

endmodule

// File: rtl/gpio_cfg_loader.sv
// Serial loader that shifts per-pad GPIO control words into NCHAIN daisy chains and latches them.
// Holds the shared sequencer (state, half-period, bit and pad counters); per-chain work is in gpio_cfg_lane.
module gpio_cfg_loader
    import gpio_cfg_pkg::*;
#(
    parameter int                NCHAIN         = 2,
    parameter int                PADS_PER_CHAIN = 19,
    parameter int                CTRL_BITS      = 13,
    parameter int                DIV_W          = 8,
    parameter logic [NCHAIN-1:0] ORDER          = {NCHAIN{1'b0}},
    parameter int                IDX_W          = cfg_clog2(NCHAIN * PADS_PER_CHAIN)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          abort,
    input  logic [DIV_W-1:0]              div,
    output logic                          busy,
    output logic                          done,
    output logic [NCHAIN*IDX_W-1:0]       cfg_rd_idx,
    input  logic [NCHAIN*CTRL_BITS-1:0]   cfg_rd_data,
    output logic                          serial_clock,
    output logic                          serial_load,
    output logic [NCHAIN-1:0]             serial_data
);

    localparam int PAD_W = cfg_clog2(PADS_PER_CHAIN);
    localparam int BIT_W = cfg_clog2(CTRL_BITS);
    localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'(PADS_PER_CHAIN - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CTRL_BITS - 1);

    state_t           state_r, state_n;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] hcnt_r, hcnt_n;
    logic             phase_r, phase_n;
    logic [BIT_W-1:0] bit_r, bit_n;
    logic [PAD_W-1:0] pad_r, pad_n;
    logic             busy_r, done_r, sclk_r, load_r;
    logic             done_n;
    logic             half_end_s, capture_s, shift_s, clear_s;
    logic             accept_s;

    assign accept_s   = (state_r == IDLE) && start && !abort;
    assign half_end_s = (hcnt_r == div_r);

    // Next-state and counter logic; phase 0/1 is the low/high half of a serial clock or the LOAD setup/strobe.
    always_comb begin
        state_n   = state_r;
        phase_n   = phase_r;
        bit_n     = bit_r;
        pad_n     = pad_r;
        done_n    = 1'b0;
        capture_s = 1'b0;
        shift_s   = 1'b0;
        clear_s   = 1'b0;

        if ((state_r != IDLE) && abort) begin
            state_n = IDLE;
            clear_s = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_n = FETCH;
                    end else begin
                        state_n = IDLE;
                    end
                end
                FETCH: begin
                    capture_s = 1'b1;
                    state_n   = SHIFT;
                end
                SHIFT: begin
                    if (half_end_s) begin
                        phase_n = ~phase_r;
                        if (phase_r) begin
                            shift_s = 1'b1;
                            if (bit_r == BIT_LAST) begin
                                bit_n = {BIT_W{1'b0}};
                                if (pad_r == PAD_LAST) begin
                                    state_n = LOAD;
                                end else begin
                                    state_n = FETCH;
                                    pad_n   = pad_r + PAD_W'(1'b1);
                                end
                            end else begin
                                bit_n = bit_r + BIT_W'(1'b1);
                            end
                        end else begin
                            shift_s = 1'b0;
                        end
                    end else begin
                        phase_n = phase_r;
                    end
                end
                LOAD: begin
                    if (half_end_s) begin
                        phase_n = ~phase_r;
                        if (phase_r) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = LOAD;
                        end
                    end else begin
                        phase_n = phase_r;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        // IDLE always parks the counters so the index port shows each chain's first pad.
        if (state_n == IDLE) begin
            phase_n = 1'b0;
            bit_n   = {BIT_W{1'b0}};
            pad_n   = {PAD_W{1'b0}};
        end else begin
            phase_n = phase_n;
        end

        if ((state_n == state_r) && !half_end_s && ((state_r == SHIFT) || (state_r == LOAD))) begin
            hcnt_n = hcnt_r + DIV_W'(1'b1);
        end else begin
            hcnt_n = {DIV_W{1'b0}};
        end
    end

    // Sequencer state and counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
            hcnt_r  <= {DIV_W{1'b0}};
            phase_r <= 1'b0;
            bit_r   <= {BIT_W{1'b0}};
            pad_r   <= {PAD_W{1'b0}};
        end else begin
            state_r <= state_n;
            hcnt_r  <= hcnt_n;
            phase_r <= phase_n;
            bit_r   <= bit_n;
            pad_r   <= pad_n;
        end
    end

    // Half-period is frozen at start so div may move freely during a transfer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_r <= {DIV_W{1'b0}};
        end else if (accept_s) begin
            div_r <= div;
        end else begin
            div_r <= div_r;
        end
    end

    // Output flops are loaded from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sclk_r <= 1'b0;
            load_r <= 1'b0;
        end else begin
            busy_r <= (state_n != IDLE);
            done_r <= done_n;
            sclk_r <= (state_n == SHIFT) && phase_n;
            load_r <= (state_n == LOAD) && phase_n;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign serial_clock = sclk_r;
    assign serial_load  = load_r;

    for (genvar c = 0; c < NCHAIN; c++) begin : g_lane
        gpio_cfg_lane #(
            .CHAIN          (c),
            .PADS_PER_CHAIN (PADS_PER_CHAIN),
            .CTRL_BITS      (CTRL_BITS),
            .IDX_W          (IDX_W),
            .PAD_W          (PAD_W),
            .ORDER_UP       (ORDER[c])
        ) u_lane (
            .clk     (clk),
            .resetn  (resetn),
            .capture (capture_s),
            .shift   (shift_s),
            .clear   (clear_s),
            .pad     (pad_n),
            .rd_data (cfg_rd_data[c*CTRL_BITS +: CTRL_BITS]),
            .rd_idx  (cfg_rd_idx[c*IDX_W +: IDX_W]),
            .data    (serial_data[c])
        );
    end

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// Self-checking bench for gpio_cfg_loader: cycle-offset reference model plus literal spot checks.
module tb_gpio_cfg_loader;

    localparam int NCHAIN = 2;
    localparam int P      = 2;
    localparam int C      = 4;
    localparam int DIV_W  = 8;
    localparam int IDX_W  = 2;
    localparam logic [NCHAIN-1:0] ORDER = 2'b10;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [DIV_W-1:0] div = 8'd0;
    logic busy, done, sclk, sload;
    logic [NCHAIN*IDX_W-1:0] rd_idx;
    logic [NCHAIN*C-1:0]     rd_data;
    logic [NCHAIN-1:0]       sdata;
    logic [C-1:0]            mem [0:NCHAIN*P-1];
    logic [NCHAIN-1:0]       order_v = ORDER;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic m_active = 1'b0;
    logic m_done   = 1'b0;
    int   m_t      = 0;
    int   m_H      = 1;

    // measurement state
    logic prev_busy = 1'b0, prev_sclk = 1'b0, prev_load = 1'b0;
    int   busy_cur = 0, busy_last = 0, hi_run = 0, hi_min = 0, hi_max = 0;
    int   load_run = 0, load_last = 0, done_cnt = 0;
    logic [31:0] cap0 = 32'd0, cap1 = 32'd0;

    gpio_cfg_loader #(
        .NCHAIN         (NCHAIN),
        .PADS_PER_CHAIN (P),
        .CTRL_BITS      (C),
        .DIV_W          (DIV_W),
        .ORDER          (ORDER)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .abort        (abort),
        .div          (div),
        .busy         (busy),
        .done         (done),
        .cfg_rd_idx   (rd_idx),
        .cfg_rd_data  (rd_data),
        .serial_clock (sclk),
        .serial_load  (sload),
        .serial_data  (sdata)
    );

    always #5 clk = ~clk;

    // zero-wait-state register file
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NCHAIN; c++) begin
            rd_data[c*C +: C] = mem[rd_idx[c*IDX_W +: IDX_W]];
        end
    end

    function automatic int total_cycles(input int h);
        return P * (1 + 2 * h * C) + 2 * h;
    endfunction

    function automatic int idx_of(input int c, input int p);
        int loc;
        loc = order_v[c] ? p : (P - 1 - p);
        return c * P + loc;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // transaction-level model: tracks only "cycles since start" and the captured half-period
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_t      <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (abort) begin
                    m_active <= 1'b0;
                end else if (m_t == total_cycles(m_H)) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end else begin
                    m_t <= m_t + 1;
                end
            end else if (start && !abort) begin
                m_active <= 1'b1;
                m_t      <= 1;
                m_H      <= int'(div) + 1;
            end
        end
    end

    // per-cycle compare against the model, plus waveform measurements
    always @(negedge clk) begin
        int period, p, r, s, b, q;
        logic e_sclk, e_load, e_fetch;
        logic [NCHAIN-1:0] e_data;
        logic [C-1:0] w;
        if (!resetn) begin
            prev_busy <= 1'b0;
            prev_sclk <= 1'b0;
            prev_load <= 1'b0;
            hi_run    <= 0;
            load_run  <= 0;
        end else begin
            e_sclk = 1'b0; e_load = 1'b0; e_fetch = 1'b0; e_data = '0; p = 0;
            if (m_active) begin
                period = 1 + 2 * m_H * C;
                if (m_t <= P * period) begin
                    p = (m_t - 1) / period;
                    r = (m_t - 1) % period;
                    if (r == 0) begin
                        e_fetch = 1'b1;
                    end else begin
                        s = r - 1;
                        b = s / (2 * m_H);
                        e_sclk = ((s % (2 * m_H)) >= m_H);
                        for (int c = 0; c < NCHAIN; c++) begin
                            w = mem[idx_of(c, p)];
                            e_data[c] = w[C-1-b];
                        end
                    end
                end else begin
                    q = m_t - 1 - P * period;
                    e_load = (q >= m_H);
                end
            end
            check("busy", {31'd0, busy}, {31'd0, m_active});
            check("done", {31'd0, done}, {31'd0, m_done});
            check("serial_clock", {31'd0, sclk}, {31'd0, e_sclk});
            check("serial_load", {31'd0, sload}, {31'd0, e_load});
            check("serial_data", {30'd0, sdata}, {30'd0, e_data});
            if (e_fetch) begin
                for (int c = 0; c < NCHAIN; c++) begin
                    check("cfg_rd_idx", {30'd0, rd_idx[c*IDX_W +: IDX_W]}, idx_of(c, p));
                end
            end

            if (sclk) begin
                hi_run <= hi_run + 1;
            end else if (prev_sclk) begin
                if (hi_run < hi_min) hi_min <= hi_run;
                if (hi_run > hi_max) hi_max <= hi_run;
                hi_run <= 0;
            end
            if (sclk && !prev_sclk) begin
                cap0 <= {cap0[30:0], sdata[0]};
                cap1 <= {cap1[30:0], sdata[1]};
            end
            if (sload) begin
                load_run <= load_run + 1;
            end else if (prev_load) begin
                load_last <= load_run;
                load_run  <= 0;
            end
            if (done) done_cnt <= done_cnt + 1;
            if (busy && !prev_busy) begin
                busy_cur <= 1;
                done_cnt <= 0;
                cap0     <= 32'd0;
                cap1     <= 32'd0;
                hi_min   <= 999999;
                hi_max   <= 0;
            end else if (busy) begin
                busy_cur <= busy_cur + 1;
            end else if (prev_busy) begin
                busy_last <= busy_cur;
            end
            prev_busy <= busy;
            prev_sclk <= sclk;
            prev_load <= sload;
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: busy still %b after %0d cycles", busy, budget);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [DIV_W-1:0] d);
        @(posedge clk); #1;
        start = 1'b1;
        div   = d;
        @(posedge clk); #1;
        start = 1'b0;
        div   = DIV_W'($urandom);
    endtask

    task automatic check_xfer(input string tag, input int len, input int hi, input int ld);
        check({tag, "_busy_len"}, busy_last, len);
        check({tag, "_clk_hi_min"}, hi_min, hi);
        check({tag, "_clk_hi_max"}, hi_max, hi);
        check({tag, "_load_len"}, load_last, ld);
        check({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_sclk"}, {31'd0, sclk}, 32'd0);
        check({tag, "_sload"}, {31'd0, sload}, 32'd0);
        check({tag, "_sdata"}, {30'd0, sdata}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        mem[0] = 4'h3; mem[1] = 4'hA; mem[2] = 4'h5; mem[3] = 4'hC;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        check("reset_idx", {28'd0, rd_idx}, 32'h9);
        resetn = 1'b1;

        // basic transfer, fastest divider; div is scrambled while busy
        pulse_start(8'd0);
        wait_idle(100);
        check_xfer("basic", 20, 1, 1);
        check("basic_chain0", cap0, 32'hA3);
        check("basic_chain1", cap1, 32'h5C);

        // H=3 with a colliding start mid-transfer
        pulse_start(8'd2);
        repeat (10) @(posedge clk);
        #1; start = 1'b1; div = 8'd0;
        @(posedge clk); #1; start = 1'b0;
        wait_idle(200);
        check_xfer("div2", 56, 3, 3);
        check("div2_chain0", cap0, 32'hA3);
        check("div2_chain1", cap1, 32'h5C);

        // start together with abort in IDLE is ignored
        @(posedge clk); #1; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        check_quiet("start_abort_idle");
        repeat (3) @(posedge clk);

        // abort during the second pad's SHIFT (H=2, second SHIFT begins at busy cycle 19)
        pulse_start(8'd1);
        repeat (21) @(posedge clk);
        #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        check_quiet("abort");
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        pulse_start(8'd0);
        wait_idle(100);
        check_xfer("after_abort", 20, 1, 1);
        check("after_abort_chain0", cap0, 32'hA3);

        // asynchronous reset while the latch strobe is high
        pulse_start(8'd3);
        n = 0;
        while (sload !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_load", {31'd0, sload}, 32'd1);
        #1; resetn = 1'b0;
        #1;
        check_quiet("async_reset");
        check("async_reset_idx", {28'd0, rd_idx}, 32'h9);
        repeat (2) @(posedge clk);
        #1; resetn = 1'b1;
        pulse_start(8'd0);
        wait_idle(100);
        check_xfer("after_reset", 20, 1, 1);

        // divider maximum: H = 256
        pulse_start(8'hFF);
        wait_idle(6000);
        check_xfer("divmax", 2 * (1 + 2048) + 512, 256, 256);

        // randomized traffic: random words, dividers, stray starts and occasional aborts
        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < NCHAIN * P; k++) begin
                mem[k] = C'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b1;
            div   = DIV_W'($urandom_range(0, 3));
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(posedge clk); #1;
                start = ($urandom_range(0, 15) == 0);
                abort = ($urandom_range(0, 299) == 0);
                div   = DIV_W'($urandom_range(0, 7));
                if (!m_active && busy === 1'b0 && cyc > 2) break;
            end
            start = 1'b0;
            abort = 1'b0;
            wait_idle(500);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_cfg_loader.md
# gpio_cfg_loader

Parametrised serial loader that shifts per-pad GPIO control words into `NCHAIN` independent daisy-chained pad configuration chains, then strobes them to latch. It sits between the management SoC's GPIO control register file and the pad control blocks. It reads control words through per-chain read ports and drives one serial clock, one load strobe and one data line per chain. Compared with the fixed two-chain loader, it adds:
- arbitrary chain count and chain length;
- per-chain shift order;
- a programmable serial clock divider;
- abort and done reporting.

## Interface
Parameters:
- `NCHAIN`, 2, number of independent serial chains.
- `PADS_PER_CHAIN`, 19, pads per chain. Global pad index = chain*PADS_PER_CHAIN + local.
- `CTRL_BITS`, 13, control bits per pad, shifted MSB first.
- `DIV_W`, 8, width of the divider input.
- `ORDER`, all-zero `NCHAIN`-bit mask. Bit c=0: chain c shifts local pad `PADS_PER_CHAIN-1` first, down to 0. Bit c=1: chain c shifts pad 0 first, up to `PADS_PER_CHAIN-1`.
- `IDX_W`, derived: clog2(`NCHAIN*PADS_PER_CHAIN`).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin a transfer.
- abort  in  1  terminate an in-progress transfer.
- div  in  `DIV_W`  half-period minus one, in clk cycles. Sampled on accepted start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse on normal completion.
- cfg_rd_idx  out  `NCHAIN*IDX_W`  per-chain global pad index being fetched.
- cfg_rd_data  in  `NCHAIN*CTRL_BITS`  combinational read data for cfg_rd_idx.
- serial_clock  out  1  shared shift clock.
- serial_load  out  1  shared latch strobe, active-high.
- serial_data  out  `NCHAIN`  per-chain serial data.

## Operation
States:
- IDLE:
  - start=1 and abort=0 → FETCH. Capture H = div+1 and reset the pad counter.
  - start with abort=1 → start ignored.
- FETCH (1 cycle):
  - cfg_rd_idx presents the current pad index for each chain, per ORDER.
  - cfg_rd_data is captured into the per-chain staging registers at cycle end.
  - → SHIFT.
- SHIFT: for each of `CTRL_BITS` bits:
  - low phase, H cycles: serial_clock=0 and serial_data = staging MSB.
  - high phase, H cycles: serial_clock=1.
  - At the end of the high phase the staging register shifts left, filling with 0.
  - After the last bit: if pads remain → FETCH with the pad counter advanced; otherwise → LOAD.
- LOAD:
  - H cycles with serial_clock=0, serial_load=0 (setup).
  - Then H cycles with serial_load=1.
  - Then → IDLE with done=1 for one cycle.
- Chains shift in lock-step. All chains share pad count, bit count and clock.

Rules and boundaries:
- start while busy: ignored. div changes while busy: ignored.
- abort while busy, any state: next cycle → IDLE. serial_clock, serial_load and serial_data go to 0. done is not pulsed. Chains are left unlatched.
- div=0 gives H=1, which is the fastest mode. div=all-ones gives H=2^DIV_W with no overflow, so the half-period counter is `DIV_W` bits wide.
- `PADS_PER_CHAIN`=1 is legal: a single FETCH/SHIFT pass, then LOAD.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous), and the state goes to IDLE.

## Timing
- Reset values:
  - busy, done, serial_clock, serial_load and serial_data are 0.
  - cfg_rd_idx = the first index of each chain per ORDER.
- Start accepted at edge N: busy=1 from cycle N+1.
- Total busy cycles = `PADS_PER_CHAIN`*(1 + 2*H*`CTRL_BITS`) + 2*H.
- done is asserted in the first cycle with busy=0.
- serial_data is stable for the full H-cycle low phase before each rising serial_clock and through the high phase.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- cfg_rd_data must be valid in the same FETCH cycle as cfg_rd_idx, i.e. a zero-wait-state register-file read.

## Structure
- Package `gpio_cfg_pkg`:
  - state enum (IDLE, FETCH, SHIFT, LOAD);
  - clog2-based width function used to derive `IDX_W`.
- Sub-module `gpio_cfg_lane`, instantiated `NCHAIN` times. It holds:
  - the per-chain staging register;
  - the index computation from the shared pad counter and ORDER bit;
  - the serial_data output.
- The sequencer (state, half-period counter, bit and pad counters) lives in `gpio_cfg_loader`.

## Test plan
- Basic transfer:
  - Stimulus: `NCHAIN`=2, `PADS_PER_CHAIN`=2, `CTRL_BITS`=4, ORDER=2'b00, div=0. Words: pad0=0x3, pad1=0xA, pad2=0x5, pad3=0xC.
  - Expected: busy for 20 cycles. Chain 0 shifts 1010 then 0011. Chain 1 shifts 1100 then 0101. One serial_load pulse of 1 cycle, then done=1 once.
- Order and divider:
  - Stimulus: same words, ORDER=2'b10, div=2.
  - Expected: H=3. Chain 1 shifts 0101 then 1100. Busy for 2*(1+24)+6 = 56 cycles. serial_clock high for exactly 3 cycles per bit.
- Abort:
  - Stimulus: assert abort during the second pad's SHIFT.
  - Expected: next cycle busy=0. serial_clock, serial_load and serial_data are 0. done never pulses. A subsequent start completes normally.
- Start collisions:
  - Stimulus: start while busy; start and abort together in IDLE.
  - Expected: both ignored. Busy length and data are unchanged.
- Async reset mid-LOAD:
  - Stimulus: drop resetn while serial_load=1.
  - Expected: serial_load drops without waiting for clk. All outputs hold reset values. IDLE after release.
- Divider maximum:
  - Stimulus: div=8'hFF, `CTRL_BITS`=4, 1 pad.
  - Expected: each half-phase lasts 256 cycles. Busy = 1 + 2048 + 512 cycles.
